// File: rtl/tx_frame_scheduler.sv
// Two-requester transmit frame scheduler: round-robin grant, fixed header delay,
// LSB-first serialisation of the PSDU bytes, then a fixed inter-frame gap.
module tx_frame_scheduler #(
    parameter int PSDU_OFFSET = 137,
    parameter int GAP         = 48
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  Req,
    input  logic [11:0] Len0,
    input  logic [11:0] Len1,
    input  logic [7:0]  DataByte,
    input  logic        DataReady,
    output logic [1:0]  Grant,
    output logic        DataAck,
    output logic        TxStart,
    output logic        TxBit,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_HEADER = 3'd2,
        S_PSDU   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    localparam logic [15:0] HDR_LAST = 16'(PSDU_OFFSET - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP);

    state_t      state_r, state_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [14:0] bit_cnt_r, bit_cnt_nxt_s;
    logic [11:0] len_r, len_nxt_s;
    logic [6:0]  shift_r, shift_nxt_s;
    logic        rr_r, rr_nxt_s;
    logic [1:0]  grant_r, grant_nxt_s;
    logic        tx_start_r, tx_start_nxt_s;
    logic        tx_bit_r, tx_bit_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;
    logic        uf_r, uf_nxt_s;
    logic        zl_nxt_s;
    logic        err_r, err_nxt_s;

    logic        sel_s;
    logic [11:0] sel_len_s;
    logic [7:0]  byte_s;
    logic [14:0] bit_inc_s;
    logic [14:0] frame_bits_s;
    logic        last_bit_s;
    logic        load_s;

    // Round-robin pick: the preferred requester wins if asking, else the other one
    always_comb begin
        if (Req[rr_r]) begin
            sel_s = rr_r;
        end else begin
            sel_s = ~rr_r;
        end
    end

    assign sel_len_s    = sel_s ? Len1 : Len0;
    assign byte_s       = DataReady ? DataByte : 8'h00;
    assign bit_inc_s    = bit_cnt_r + 15'd1;
    assign frame_bits_s = {len_r, 3'b000};
    assign last_bit_s   = (bit_inc_s == frame_bits_s);
    // A byte is fetched at the end of the header and after every 8th bit except the final one
    assign load_s       = ((state_r == S_HEADER) && (cnt_r == HDR_LAST)) ||
                          ((state_r == S_PSDU) && (bit_cnt_r[2:0] == 3'd7) && !last_bit_s);
    assign DataAck      = load_s & DataReady & Reset;

    // Next-state and next-output computation for the frame sequencer
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        len_nxt_s      = len_r;
        shift_nxt_s    = shift_r;
        rr_nxt_s       = rr_r;
        grant_nxt_s    = grant_r;
        tx_start_nxt_s = 1'b0;
        tx_bit_nxt_s   = 1'b0;
        done_nxt_s     = 1'b0;
        uf_nxt_s       = uf_r;
        zl_nxt_s       = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (Req != 2'b00) begin
                    if (sel_len_s != 12'd0) begin
                        len_nxt_s      = sel_len_s;
                        grant_nxt_s    = sel_s ? 2'b10 : 2'b01;
                        rr_nxt_s       = ~sel_s;
                        tx_start_nxt_s = 1'b1;
                        uf_nxt_s       = 1'b0;
                        state_nxt_s    = S_START;
                    end else begin
                        zl_nxt_s = 1'b1;
                        rr_nxt_s = ~sel_s;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                cnt_nxt_s   = 16'd1;
                state_nxt_s = S_HEADER;
            end
            S_HEADER: begin
                if (cnt_r == HDR_LAST) begin
                    state_nxt_s   = S_PSDU;
                    bit_cnt_nxt_s = 15'd0;
                    tx_bit_nxt_s  = byte_s[0];
                    shift_nxt_s   = byte_s[7:1];
                    uf_nxt_s      = uf_r | ~DataReady;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            S_PSDU: begin
                done_nxt_s = ((bit_cnt_r + 15'd2) == frame_bits_s);
                if (last_bit_s) begin
                    state_nxt_s = S_GAP;
                    cnt_nxt_s   = 16'd1;
                end else if (load_s) begin
                    bit_cnt_nxt_s = bit_inc_s;
                    tx_bit_nxt_s  = byte_s[0];
                    shift_nxt_s   = byte_s[7:1];
                    uf_nxt_s      = uf_r | ~DataReady;
                end else begin
                    bit_cnt_nxt_s = bit_inc_s;
                    tx_bit_nxt_s  = shift_r[0];
                    shift_nxt_s   = {1'b0, shift_r[6:1]};
                end
            end
            S_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s = S_IDLE;
                    grant_nxt_s = 2'b00;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                grant_nxt_s = 2'b00;
            end
        endcase

        busy_nxt_s = (state_nxt_s != S_IDLE);
        err_nxt_s  = uf_nxt_s | zl_nxt_s;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= 16'd0;
            bit_cnt_r  <= 15'd0;
            len_r      <= 12'd0;
            shift_r    <= 7'd0;
            rr_r       <= 1'b0;
            grant_r    <= 2'b00;
            tx_start_r <= 1'b0;
            tx_bit_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            uf_r       <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            len_r      <= len_nxt_s;
            shift_r    <= shift_nxt_s;
            rr_r       <= rr_nxt_s;
            grant_r    <= grant_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            tx_bit_r   <= tx_bit_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            uf_r       <= uf_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign Grant   = grant_r;
    assign TxStart = tx_start_r;
    assign TxBit   = tx_bit_r;
    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Error   = err_r;

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have parameter PSDU_OFFSET, default 137: cycles from the TxStart cycle to the first PSDU bit cycle (96 preamble + 24 signal + 16 service + 1).
REQ-002 SHALL have parameter GAP, default 48: cycles held after the last PSDU bit, covering tail, pad and inter-frame space.
REQ-003 Clock  in  1  single clock; all logic on its rising edge.
REQ-004 Reset  in  1  synchronous, active-low reset.
REQ-005 Req  in  2  per-requester frame request, level.
REQ-006 Len0, Len1  in  12 each  PSDU length in octets per requester; valid while the matching Req is high.
REQ-007 DataByte  in  8  PSDU byte from the granted requester.
REQ-008 DataReady  in  1  DataByte valid.
REQ-009 Grant  out  2  one-hot owner of the transmitter; 2'b00 when free.
REQ-010 DataAck  out  1  byte accepted this cycle; the requester advances on that edge.
REQ-011 TxStart  out  1  one-cycle start pulse to the transmitter.
REQ-012 TxBit  out  1  registered serial PSDU bit to the transmitter Input.
REQ-013 Busy  out  1  high in every state except IDLE.
REQ-014 Done  out  1  one-cycle pulse in the last PSDU bit cycle.
REQ-015 Error  out  1  sticky underflow/zero-length flag; cleared at the next grant.

Function
REQ-016 States SHALL be IDLE, START, HEADER, PSDU, GAP, in that order; no other transitions except reset.
REQ-017 IDLE: when any Req is high with Len of the selected requester ≠ 0 at edge t, SHALL latch Len into a 12-bit register, set Grant and enter START; TxStart=1 in cycle t+1 (c0).
REQ-018 Arbitration SHALL be round-robin. On simultaneous Req, the requester not granted most recently wins. After reset, requester 0 wins.
REQ-019 Zero length: if the selected requester has Len=0, SHALL pulse Error for one cycle, issue no TxStart and no Grant, remain IDLE, and advance the round-robin pointer past that requester.
REQ-020 START lasts exactly one cycle. HEADER covers cycles c0+1..c0+PSDU_OFFSET-1.
REQ-021 Byte load: in cycle c0+PSDU_OFFSET-1 and in every 8th PSDU cycle thereafter, SHALL request a byte. If DataReady=1, DataAck=1 that cycle and DataByte loads the shift register.
REQ-022 Underflow: if DataReady=0 at a load point, SHALL load 8'h00, keep DataAck=0, set Error, and continue. The frame is never aborted.
REQ-023 PSDU covers cycles c0+PSDU_OFFSET..c0+PSDU_OFFSET+8*Len-1. TxBit SHALL be sent LSB first. TxBit=0 in all other states.
REQ-024 Bit counter SHALL be 15 bits and compare against {Len,3'b000} with no overflow up to Len=4095.
REQ-025 GAP SHALL last exactly GAP cycles, then the block enters IDLE. The earliest next TxStart is at c0+PSDU_OFFSET+8*Len+GAP+1.
REQ-026 Grant SHALL stay constant from START to the end of GAP. Req changes during a frame are ignored. Len is used only as latched.
REQ-027 DataAck SHALL never assert outside load points; exactly Len acks per frame when there is no underflow.

Reset
REQ-028 Reset=0 at an edge SHALL force IDLE, set Grant, DataAck, TxStart, TxBit, Busy, Done and Error to 0, clear counters and point round-robin at requester 0. This applies mid-frame, with no further TxStart.
REQ-029 Release SHALL take effect on the first edge with Reset=1. A Req held through reset is granted on the next edge.

Verification
REQ-030 Req0=1, Len0=1, DataByte=8'hA5, DataReady=1 at t -> Grant=01 and TxStart at t+1 = c0. DataAck at c0+136. TxBit c0+137..c0+144 = 1,0,1,0,0,1,0,1. Done at c0+144. Busy falls at c0+193.
REQ-031 Req0=Req1=1 after reset, Len=2, both held -> first grant 01, second 10, third 01. TxStart spacing = 1+136+16+48+1 = 202 cycles.
REQ-032 Len1=0, Req1 alone -> Error pulse, no TxStart, Grant=00, Busy=0.
REQ-033 Len0=3, DataReady=0 at the second load point -> second byte sent as 8 zeros, Error=1, two DataAcks total, frame length unchanged.
REQ-034 Reset=0 at c0+140 -> Busy=0 and TxBit=0 on the next cycle, no TxStart. A held Req0 is regranted on the first edge after release.
REQ-035 Len0=4095 -> 32760 PSDU bits, 4095 DataAcks, Done at c0+136+32760.
